prog_counter: RTL
=================

# prog_counter

Parametrised programmable counter, the successor to the free-running 8-bit counter used in the simple test designs. It adds configurable width, an up/down direction, a programmable terminal value, a prescaler, parallel load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It is the standard sequential leaf for simulator regression designs and for timer/event logic in larger test RTL.

## Interface

Parameters:
- WIDTH, 8, counter width in bits (≥2)
- PRESCALE_W, 4, prescaler select width (≥1)
- SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  count enable; gates prescaler and counter
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_value  input  WIDTH  value written on load
- limit  input  WIDTH  terminal value; count range is 0..limit
- prescale  input  PRESCALE_W  one step per (prescale+1) enabled cycles
- clear_ovf  input  1  clears sticky ovf
- value  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle
- ovf  output  1  sticky terminal-reached flag, registered

## Operation

- Internal prescaler pre_cnt (PRESCALE_W bits). On each edge with en=1 and load=0:
  - if pre_cnt == prescale: step=1 and pre_cnt→0
  - else pre_cnt+1
- en=0: pre_cnt and value hold; no step.
- Priority per edge: load > step > hold.
- Load: value←load_value and pre_cnt←0, regardless of en. Load produces no tc.
- Up step:
  - if value ≥ limit: terminal. SATURATE=0: value←0. SATURATE=1: value←limit.
  - else value+1.
- Down step:
  - if value == 0: terminal. SATURATE=0: value←limit. SATURATE=1: value←0.
  - else value−1.
  - A down step with value > limit is not terminal; value decrements normally.
- limit=0: every up or down step is terminal; value stays 0.
- Arithmetic never relies on 2^WIDTH overflow; the comparisons guard both ends.
- tc: registered, high for the cycle following the edge on which a terminal step occurred, low otherwise. Repeated terminal steps (saturate, limit=0, prescale=0) keep tc high on consecutive cycles.
- ovf: set on any terminal step. Cleared by clear_ovf. Set wins if both happen on the same edge.
- limit, prescale and up are sampled every edge; changes take effect immediately. Lowering prescale below pre_cnt does not step until pre_cnt wraps, by natural PRESCALE_W rollover (all-ones → 0).

## Timing

- Reset (async assert, any time, including mid-count or mid-load): value=0, pre_cnt=0, tc=0, ovf=0 immediately, without waiting for a clock edge.
- Release: the first edge with rst low may count.
- Latency:
  - Load: value updates on the edge sampling load=1.
  - Step: value updates on the edge where the prescaler matches.
  - tc/ovf: change on that same edge.
- With prescale=0 and en=1 held, value changes every cycle.
- With prescale=P, value changes every P+1 enabled cycles. The first step occurs on the (P+1)th enabled edge after reset or load.
- No combinational path from inputs to outputs.

## Test plan

- WIDTH=8, limit=255, prescale=0, up=1, en=1 after reset: value 0,1,…,255,0. tc high only in the cycle value reads 0 after 255. ovf=1 from then on.
- limit=9, prescale=2, up=1: value increments every 3rd cycle 0→9→0. tc one cycle per 30 cycles. Drop en for 5 cycles mid-run: value and phase frozen, then resume exactly.
- SATURATE=1, up=0, load_value=3, load: value 3,2,1,0,0,0. tc high from the first 0→0 step onward. Assert clear_ovf together with a terminal step: ovf stays 1.
- Load 200 with limit=100, up=1: the next step gives 0 and tc. Load 200 with up=0: 199. load together with a prescaler match: load wins, no tc.
- Assert rst asynchronously between edges with value=0x5A, ovf=1: outputs read 0 before the next edge. Release: counting restarts from 0 with full prescale delay.
- limit=0, prescale=0, en=1: value stays 0, tc continuously high, ovf=1. Clear_ovf pulse: ovf remains 1.

Source files
------------

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, parallel load, wrap or saturate
// at a programmable terminal value, a one-cycle terminal-count pulse and a
// sticky overflow flag. All outputs are registered.
module prog_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clear_ovf,
  output logic [WIDTH-1:0]      value,
  output logic                  tc,
  output logic                  ovf
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]      value_q, value_d;
  logic                  tc_q, tc_d;
  logic                  ovf_q, ovf_d;

  logic pre_match;
  logic step;
  logic terminal;

  // Prescaler: a step fires on the enabled edge where pre_cnt equals prescale.
  // Equality (not >=) is deliberate: lowering prescale below pre_cnt lets the
  // prescaler run on to its natural rollover before the next step.
  always_comb begin
    pre_match = (pre_cnt_q == prescale);
    step      = en && !load && pre_match;
    pre_cnt_d = pre_cnt_q;
    if (load) begin
      pre_cnt_d = '0;
    end else if (en) begin
      if (pre_match) begin
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  // Counter next state. Terminal detection guards both ends so the arithmetic
  // never depends on 2^WIDTH rollover; a down step above limit is not terminal.
  always_comb begin
    value_d  = value_q;
    terminal = 1'b0;
    if (load) begin
      value_d = load_value;
    end else if (step) begin
      if (up) begin
        if (value_q >= limit) begin
          terminal = 1'b1;
          value_d  = SATURATE ? limit : '0;
        end else begin
          value_d = value_q + WIDTH'(1);
        end
      end else begin
        if (value_q == '0) begin
          terminal = 1'b1;
          value_d  = SATURATE ? '0 : limit;
        end else begin
          value_d = value_q - WIDTH'(1);
        end
      end
    end
  end

  // Flags: tc mirrors this edge's terminal step; ovf set has priority over clear.
  always_comb begin
    tc_d  = terminal;
    ovf_d = ovf_q;
    if (terminal) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      value_q   <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      value_q   <= value_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign value = value_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
